mc_core_p: RTL and testbench

- Parametrised multi-cycle accumulator-style CPU core: FETCH / EXECUTE / MEMORY sequencer over a 32-entry register file, with R31 as the program counter.
- Successor generation: configurable data and address width, configurable reset vector, and synchronous reset.
- Variable-latency memory through a req/ack handshake.
- Conditional branch, direct PC writes without a trailing increment, a resumable halt, and a retired-instruction counter.
- ALU stays a separate module, connected through the alu_* ports.

---
 rtl/mc_core_p.sv | 90 +++++++++
 tb/tb_mc_core_p.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_core_p.sv
// mc_core_p: multi-cycle accumulator CPU core, FETCH/EXEC/MEM/HALT sequencer over a 32-entry RF with R31 as PC
module mc_core_p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_pc,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              resume,
  output logic              halted,
  output logic [2:0]        ins_type,
  output logic [DATA_W-1:0] retired
);
  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] rf [32];
  logic [31:0] instr;
  logic [2:0] t;
  logic [3:0] op;
  logic [4:0] a, b, c;
  logic [DATA_W-1:0] ra, rb, rc, pc, pc_n, wr_data;
  logic calc, exec_st, mem_done, wr_en, pc_en, retire;
  assign t = instr[2:0];
  assign op = instr[6:3];
  assign a = instr[11:7];
  assign b = instr[16:12];
  assign c = instr[21:17];
  assign ra = rf[a];
  assign rb = rf[b];
  assign rc = rf[c];
  assign pc = rf[31];
  // state register
  always_ff @(posedge clk)
    if (rst) state <= FETCH;
    else state <= state_n;
  // sequencing: memory phases wait for ack, HALT waits for resume
  always_comb
    state_n = state == FETCH ? (mem_ack ? EXEC : FETCH) :
              state == EXEC  ? (t == 3'd4 ? MEM : t == 3'd6 ? HALT : FETCH) :
              state == MEM   ? (mem_ack ? FETCH : MEM) :
                               (resume ? FETCH : HALT);
  // ALU operand routing and memory/status outputs, quiet while in reset
  always_comb begin
    alu_op = op;
    ins_type = t;
    alu_pc = pc;
    alu_a = t == 3'd1 ? DATA_W'(instr[31:12]) : rb;
    alu_b = t == 3'd2 ? DATA_W'(instr[31:17]) : rc;
    mem_req = !rst && (state == FETCH || state == MEM);
    mem_we = state == MEM && op[0];
    mem_addr = state == MEM ? rb[ADDR_W-1:0] : pc[ADDR_W-1:0];
    mem_wdata = ra;
    halted = !rst && state == HALT;
  end
  // writeback selection; a write to R31 replaces the PC increment
  always_comb begin
    calc = t inside {3'd1, 3'd2, 3'd3};
    exec_st = state == EXEC;
    mem_done = state == MEM && mem_ack;
    wr_en = (exec_st && calc) || (mem_done && !op[0]);
    wr_data = state == MEM ? mem_rdata : alu_r;
    pc_n = exec_st && t == 3'd5 && ra == '0 ? rb : pc + 1'b1;
    pc_en = (exec_st && t != 3'd4 && t != 3'd6) || mem_done || (state == HALT && resume);
    retire = (exec_st && t != 3'd4) || mem_done;
  end
  // register file, instruction latch and retired counter
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 31; i++) rf[i] <= '0;
      rf[31] <= RESET_PC;
      instr <= '0;
      retired <= '0;
    end else begin
      if (state == FETCH && mem_ack) instr <= 32'(mem_rdata);
      if (pc_en) rf[31] <= pc_n;
      if (wr_en) rf[a] <= wr_data;
      if (retire) retired <= retired + 1'b1;
    end
endmodule

// File: tb/tb_mc_core_p.sv
// tb_mc_core_p: directed program tables plus random programs checked against an instruction-level model
module tb_mc_core_p;
  localparam int DW = 24;
  localparam int AW = 8;
  localparam logic [DW-1:0] RPC = 24'h10;
  logic clk = 0, rst = 1, resume = 0, ack_force = 0;
  logic mem_req, mem_we, mem_ack, halted;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, alu_a, alu_b, alu_pc, alu_r, retired;
  logic [3:0] alu_op;
  logic [2:0] ins_type;
  logic [DW-1:0] ram [256];
  logic [DW-1:0] mref [256];
  logic [DW-1:0] m [32];
  logic [DW-1:0] ret;
  int checks = 0, errors = 0, wcnt = 0, wlim = 0, wfix = 0;
  bit rwait = 0;
  typedef struct {logic [7:0] ad; logic [23:0] ins; int cyc; logic [23:0] nxt;} vec_t;
  vec_t tbl [22];

  mc_core_p #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_pc(alu_pc), .alu_r(alu_r), .resume(resume),
    .halted(halted), .ins_type(ins_type), .retired(retired));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a, b, pc);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return pc + b;
      default: return b;
    endcase
  endfunction

  assign alu_r = alu_f(alu_op, alu_a, alu_b, alu_pc);
  assign mem_rdata = ram[mem_addr];
  assign mem_ack = ack_force || (mem_req && wcnt >= wlim);

  always @(posedge clk) begin
    wcnt <= (rst || !mem_req || mem_ack) ? 0 : wcnt + 1;
    if (rst || (mem_req && mem_ack)) wlim <= rwait ? int'($urandom_range(0, 2)) : wfix;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m = '{default: '0};
    m[31] = RPC;
    ret = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_halted", halted, 1'b0);
    rst = 0;
    mreset();
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0;
      mref[i] = '0;
    end
  endtask

  task automatic load(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ram[tbl[i].ad] = tbl[i].ins;
      mref[tbl[i].ad] = tbl[i].ins;
    end
  endtask

  task automatic await_ack(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd, inout int cyc);
    int k = 0;
    while (!mem_ack && k < 40) begin
      @(negedge clk);
      #1;
      cyc++;
      k++;
      chk("wait_req", mem_req, 1'b1);
      chk("wait_we", mem_we, we);
      chk("wait_addr", mem_addr, ad);
      if (we) chk("wait_wdata", mem_wdata, wd);
    end
    chk("ack_seen", mem_ack, 1'b1);
  endtask

  task automatic step(output int cyc);
    logic [31:0] ins;
    logic [DW-1:0] ea, eb;
    logic [AW-1:0] ad;
    logic [2:0] t;
    logic [3:0] op;
    logic [4:0] a, b, c;
    cyc = 1;
    chk("fetch_req", mem_req, 1'b1);
    chk("fetch_we", mem_we, 1'b0);
    chk("fetch_addr", mem_addr, m[31][AW-1:0]);
    chk("pc", alu_pc, m[31]);
    chk("retired", retired, ret);
    chk("halted_run", halted, 1'b0);
    await_ack(1'b0, m[31][AW-1:0], '0, cyc);
    ins = 32'(mref[m[31][AW-1:0]]);
    chk("fetch_data", mem_rdata, ins);
    t = ins[2:0]; op = ins[6:3]; a = ins[11:7]; b = ins[16:12]; c = ins[21:17];
    @(negedge clk);
    #1;
    cyc++;
    chk("exec_req", mem_req, 1'b0);
    chk("exec_halted", halted, 1'b0);
    chk("ins_type", ins_type, t);
    chk("alu_op", alu_op, op);
    ea = t == 3'd1 ? DW'(ins[31:12]) : m[b];
    eb = t == 3'd2 ? DW'(ins[31:17]) : m[c];
    if (t inside {3'd1, 3'd2, 3'd3}) begin
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      m[31] = m[31] + 1'b1;
      m[a] = alu_f(op, ea, eb, alu_pc);
      ret++;
    end else if (t == 3'd5) begin
      m[31] = m[a] == '0 ? m[b] : m[31] + 1'b1;
      ret++;
    end else if (t == 3'd4) begin
      @(negedge clk);
      #1;
      cyc++;
      ad = m[b][AW-1:0];
      chk("mem_req", mem_req, 1'b1);
      chk("mem_we", mem_we, op[0]);
      chk("mem_addr", mem_addr, ad);
      chk("mem_wdata", mem_wdata, m[a]);
      await_ack(op[0], ad, m[a], cyc);
      if (mem_we) ram[mem_addr] = mem_wdata;
      m[31] = m[31] + 1'b1;
      if (op[0]) mref[ad] = m[a];
      else begin
        chk("load_data", mem_rdata, mref[ad]);
        m[a] = mref[ad];
      end
      ret++;
    end else if (t == 3'd6) begin
      ret++;
      @(negedge clk);
      #1;
      chk("halt_flag", halted, 1'b1);
      chk("halt_req", mem_req, 1'b0);
      chk("halt_retired", retired, ret);
      chk("halt_pc", alu_pc, m[31]);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        #1;
        chk("halt_hold", halted, 1'b1);
      end
      resume = 1;
      @(negedge clk);
      resume = 0;
      m[31] = m[31] + 1'b1;
      #1;
    end else begin
      m[31] = m[31] + 1'b1;
      ret++;
    end
    if (t != 3'd6) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run_tbl(input int lo, input int hi, input bit cc, output int tot);
    int cyc;
    tot = 0;
    for (int i = lo; i <= hi; i++) begin
      step(cyc);
      tot += cyc;
      if (cc) chk("cycles", cyc, tbl[i].cyc);
      chk("next_pc", alu_pc, tbl[i].nxt);
    end
  endtask

  initial begin
    int tot, cyc;
    tbl[0]  = '{8'h10, 24'h005081, 2, 24'h000011};
    tbl[1]  = '{8'h11, 24'h061102, 2, 24'h000012};
    tbl[2]  = '{8'h12, 24'h00010C, 3, 24'h000013};
    tbl[3]  = '{8'h13, 24'h000184, 3, 24'h000014};
    tbl[4]  = '{8'h14, 24'h000006, 2, 24'h000015};
    tbl[5]  = '{8'h15, 24'h00018C, 3, 24'h000016};
    tbl[6]  = '{8'h10, 24'h000201, 2, 24'h000011};
    tbl[7]  = '{8'h11, 24'h040281, 2, 24'h000012};
    tbl[8]  = '{8'h12, 24'h005205, 2, 24'h000040};
    tbl[9]  = '{8'h40, 24'h001201, 2, 24'h000041};
    tbl[10] = '{8'h41, 24'h005205, 2, 24'h000042};
    tbl[11] = '{8'h42, 24'h020F81, 2, 24'h000020};
    tbl[12] = '{8'h20, 24'h000F84, 3, 24'h000007};
    tbl[13] = '{8'h07, 24'h001381, 2, 24'h000008};
    tbl[14] = '{8'h08, 24'h007F84, 3, 24'hFFFFFF};
    tbl[15] = '{8'hFF, 24'h000000, 2, 24'h000000};
    tbl[16] = '{8'h00, 24'h000007, 2, 24'h000001};
    tbl[17] = '{8'h01, 24'hFFFFFF, 2, 24'h000002};
    tbl[18] = '{8'h02, 24'h91A401, 2, 24'h000003};
    tbl[19] = '{8'h03, 24'h02842A, 2, 24'h000004};
    tbl[20] = '{8'h04, 24'h00840C, 3, 24'h000005};
    tbl[21] = '{8'h05, 24'h000006, 2, 24'h000006};

    clear_mem();
    load(0, 5);
    wfix = 0;
    do_reset();
    chk("first_addr", mem_addr, 8'h10);
    chk("first_req", mem_req, 1'b1);
    chk("first_retired", retired, 24'h0);
    run_tbl(0, 4, 1, tot);
    chk("prog_cycles_w0", tot, 12);
    run_tbl(5, 5, 1, tot);
    chk("r3_stored", ram[0], 24'h8);
    chk("retired_6", retired, 24'h6);

    clear_mem();
    load(0, 5);
    wfix = 3;
    do_reset();
    run_tbl(0, 4, 0, tot);
    chk("prog_cycles_w3", tot, 12 + 7 * 3);
    run_tbl(5, 5, 0, tot);
    chk("r3_stored_w3", ram[0], 24'h8);
    chk("retired_6_w3", retired, 24'h6);

    clear_mem();
    load(6, 21);
    wfix = 0;
    do_reset();
    run_tbl(6, 21, 1, tot);
    chk("trunc_store", ram[8'h34], 24'h1234);

    clear_mem();
    load(0, 5);
    wfix = 6;
    do_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("pre_rst_wait", mem_req, 1'b1);
    rst = 1;
    ack_force = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_req", mem_req, 1'b0);
    chk("midrst_halted", halted, 1'b0);
    rst = 0;
    ack_force = 0;
    mreset();
    #1;
    chk("post_rst_addr", mem_addr, 8'h10);
    chk("post_rst_pc", alu_pc, 24'h10);
    chk("post_rst_retired", retired, 24'h0);
    step(cyc);
    chk("post_rst_next", alu_pc, 24'h11);

    wfix = 0;
    rwait = 1;
    for (int i = 0; i < 256; i++) begin
      ram[i] = DW'($urandom);
      mref[i] = ram[i];
    end
    do_reset();
    repeat (300) step(cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
